// File: rtl/tile_column_mac.sv
// tile_column_mac
//   Per-lane multiply-accumulate over the columns of one A tile in the
//   GEMMV datapath. Each accepted beat carries one reorganised tile column
//   plus the matching x element. After num_cols beats the per-lane partial
//   y sums are presented on a registered valid/ready output. The next tile
//   can accumulate while the previous result waits to be consumed.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : column beat valid
//   in_ready   : beat can be accepted this cycle (combinational)
//   col_data   : signed lanes, lane i at [i*data_width +: data_width]
//   x_data     : signed x element for this column
//   out_valid  : tile result valid
//   out_ready  : downstream accepts the result
//   out_data   : signed per-lane sums, lane i at [i*acc_width +: acc_width]
//   col_idx    : index of the next column to be accepted
module tile_column_mac #(
  parameter int data_width         = 20,
  parameter int a_tile_column_size = 4,
  parameter int acc_width          = 48,
  parameter int num_cols           = 4,
  localparam int CW = (num_cols > 1) ? $clog2(num_cols) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [data_width*a_tile_column_size-1:0] col_data,
  input  logic [data_width-1:0]                    x_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [acc_width*a_tile_column_size-1:0]  out_data,
  output logic [CW-1:0]                            col_idx
);

  logic signed [2*data_width-1:0] prod     [a_tile_column_size];
  logic signed [acc_width-1:0]    acc_q    [a_tile_column_size];
  logic signed [acc_width-1:0]    sum_d    [a_tile_column_size];

  logic [acc_width*a_tile_column_size-1:0] out_data_q, out_data_d;
  logic [CW-1:0]                           col_q, col_d;
  logic                                    out_valid_q, out_valid_d;
  logic                                    last_col, in_fire, out_fire;

  assign last_col = (col_q == CW'(num_cols - 1));

  // Only the completing column needs the output register to be free; it may
  // become free in the same cycle through an output transfer.
  assign in_ready = !(last_col && out_valid_q && !out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Operands are sign-extended to the full product width before the multiply
  // so the product is exact; the product is then sign-extended to acc_width.
  always_comb begin
    for (int unsigned i = 0; i < a_tile_column_size; i++) begin
      prod[i] = (2*data_width)'($signed(col_data[i*data_width +: data_width]))
              * (2*data_width)'($signed(x_data));
    end
  end

  // The first column of a tile overwrites the accumulator instead of adding.
  always_comb begin
    for (int unsigned i = 0; i < a_tile_column_size; i++) begin
      sum_d[i] = ((col_q == '0) ? '0 : acc_q[i]) + acc_width'(prod[i]);
    end
  end

  always_comb begin
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_fire) begin
      out_valid_d = 1'b0;
    end
    // A completing beat in the same cycle as an output transfer takes
    // precedence, giving back-to-back tiles without a bubble.
    if (in_fire) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) begin
        out_valid_d = 1'b1;
        for (int unsigned i = 0; i < a_tile_column_size; i++) begin
          out_data_d[i*acc_width +: acc_width] = sum_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int unsigned i = 0; i < a_tile_column_size; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (in_fire) begin
        for (int unsigned i = 0; i < a_tile_column_size; i++) begin
          acc_q[i] <= sum_d[i];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign col_idx   = col_q;

endmodule

// File: tb/tb_tile_column_mac.sv
module tb_tile_column_mac;
  localparam int DW = 20;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int NC = 4;

  typedef logic signed [DW-1:0] lane_t;
  typedef logic [AW*N-1:0]      res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW*N-1:0] col_data;
  logic [DW-1:0]   x_data;
  logic            out_valid;
  logic            out_ready;
  res_t            out_data;
  logic [1:0]      col_idx;

  int checks = 0;
  int errors = 0;

  // Current tile: ta[column][lane], tx[column]
  lane_t ta [NC][N];
  lane_t tx [NC];
  res_t  exp_a;

  tile_column_mac #(
    .data_width(DW),
    .a_tile_column_size(N),
    .acc_width(AW),
    .num_cols(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .col_data(col_data),
    .x_data(x_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input res_t obs, input res_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain dot product per lane over the whole tile, mod 2^AW.
  function automatic res_t tile_sum();
    res_t   r;
    longint s;
    r = '0;
    for (int l = 0; l < N; l++) begin
      s = 0;
      for (int c = 0; c < NC; c++) s += longint'(ta[c][l]) * longint'(tx[c]);
      r[l*AW +: AW] = s[AW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW*N-1:0] pack_col(input int c);
    logic [DW*N-1:0] v;
    for (int l = 0; l < N; l++) v[l*DW +: DW] = ta[c][l];
    return v;
  endfunction

  task automatic load_basic();
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < N; l++) ta[c][l] = lane_t'(l + 1);
      tx[c] = lane_t'(1);
    end
  endtask

  task automatic load_random();
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < N; l++) ta[c][l] = lane_t'($urandom);
      tx[c] = lane_t'($urandom);
    end
  endtask

  // Called at posedge+1; leaves in_valid high after the accepting edge.
  task automatic send(input int c, input int max_wait, input string tag);
    bit ok;
    ok       = 1'b0;
    col_data = pack_col(c);
    x_data   = tx[c];
    in_valid = 1'b1;
    #1;
    for (int w = 0; w <= max_wait; w++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s_accept observed=stalled expected=accepted col %0d", tag, c);
    end
    if (ok) chk({tag, "_col_idx"}, res_t'(col_idx), res_t'((c + 1) % NC));
  endtask

  task automatic send_tile(input string tag, input int max_bubble);
    int n;
    for (int c = 0; c < NC; c++) begin
      if (c > 0 && max_bubble > 0) begin
        n        = $urandom_range(max_bubble, 0);
        in_valid = 1'b0;
        col_data = {$urandom, $urandom, $urandom};
        x_data   = DW'($urandom);
        repeat (n) begin @(posedge clk); #1; end
        if (n > 0) chk({tag, "_hold_col_idx"}, res_t'(col_idx), res_t'(c));
      end
      send(c, 8, tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_consumed_valid"}, res_t'(out_valid), res_t'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    col_data  = '0;
    x_data    = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", res_t'(out_valid), res_t'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_col_idx", res_t'(col_idx), res_t'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", res_t'(in_ready), res_t'(1));

    // Basic tile
    load_basic();
    for (int c = 0; c < NC; c++) begin
      chk("basic_in_ready", res_t'(in_ready), res_t'(1));
      send(c, 0, "basic");
    end
    in_valid = 1'b0;
    chk("basic_out_valid", res_t'(out_valid), res_t'(1));
    chk("basic_out_const", out_data, {48'd16, 48'd12, 48'd8, 48'd4});
    chk("basic_out_model", out_data, tile_sum());
    consume("basic");

    // Signed extremes
    for (int c = 0; c < NC; c++) begin
      ta[c][0] = lane_t'(-1);
      ta[c][1] = lane_t'(-524288);
      ta[c][2] = '0;
      ta[c][3] = '0;
      tx[c]    = lane_t'(-524288);
    end
    send_tile("ext", 0);
    chk("ext_out_valid", res_t'(out_valid), res_t'(1));
    chk("ext_out_const", out_data, {48'd0, 48'd0, 48'h100_0000_0000, 48'd2097152});
    chk("ext_out_model", out_data, tile_sum());
    consume("ext");

    // Backpressure: tile A held, tile B stalls at its completing column
    load_random();
    send_tile("bpA", 0);
    exp_a = tile_sum();
    chk("bpA_out_valid", res_t'(out_valid), res_t'(1));
    chk("bpA_out_data", out_data, exp_a);
    load_random();
    for (int c = 0; c < NC - 1; c++) send(c, 0, "bpB");
    col_data = pack_col(NC - 1);
    x_data   = tx[NC - 1];
    #1;
    chk("bp_stall_in_ready", res_t'(in_ready), res_t'(0));
    chk("bp_stall_hold_a", out_data, exp_a);
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_stall_col_idx", res_t'(col_idx), res_t'(NC - 1));
    chk("bp_stall_hold_a2", out_data, exp_a);
    chk("bp_stall_valid", res_t'(out_valid), res_t'(1));
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", res_t'(in_ready), res_t'(1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bpB_out_valid", res_t'(out_valid), res_t'(1));
    chk("bpB_out_data", out_data, tile_sum());
    chk("bpB_col_idx", res_t'(col_idx), res_t'(0));
    consume("bpB");

    // Bubbles between beats
    load_basic();
    send_tile("bub", 3);
    chk("bub_out_valid", res_t'(out_valid), res_t'(1));
    chk("bub_out_const", out_data, {48'd16, 48'd12, 48'd8, 48'd4});
    consume("bub");
    for (int t = 0; t < 3; t++) begin
      load_random();
      send_tile("bubr", 3);
      chk("bubr_out_data", out_data, tile_sum());
      consume("bubr");
    end

    // Back-to-back tiles with out_ready held high
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      load_random();
      for (int c = 0; c < NC; c++) begin
        send(c, 0, "b2b");
        if (c == 0 && t > 0) chk("b2b_valid_drop", res_t'(out_valid), res_t'(0));
      end
      chk("b2b_out_valid", res_t'(out_valid), res_t'(1));
      chk("b2b_out_data", out_data, tile_sum());
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_final_valid", res_t'(out_valid), res_t'(0));

    // Mid-tile reset discards the partial sums
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < N; l++) ta[c][l] = lane_t'(7);
      tx[c] = lane_t'(7);
    end
    send(0, 0, "mid7");
    send(1, 0, "mid7");
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_col_idx", res_t'(col_idx), res_t'(0));
    chk("mid_rst_valid", res_t'(out_valid), res_t'(0));
    load_basic();
    send_tile("mid", 0);
    chk("mid_out_valid", res_t'(out_valid), res_t'(1));
    chk("mid_out_const", out_data, {48'd16, 48'd12, 48'd8, 48'd4});
    consume("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
